// File: rtl/pe_sequencer.sv
// pe_sequencer: fetch/decode/execute sequencer feeding one shared opcode to a LANES-wide PE array.
// Build option PE_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter output (cycle_count).
module pe_sequencer #(
    parameter int LANES   = 4,
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IADDR_W-1:0]    imem_addr,
    input  logic [15:0]           imem_rdata,
    output logic [DADDR_W-1:0]    dmem_addr,
    input  logic [LANES*32-1:0]   dmem_rdata,
    output logic [LANES*32-1:0]   dmem_wdata,
    output logic                  dmem_we,
    output logic [3:0]            pe_opcode,
    output logic [LANES*32-1:0]   pe_a,
    output logic [LANES*32-1:0]   pe_b,
    input  logic [LANES*32-1:0]   pe_out
`ifdef PE_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycle_count
`endif
);
    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD_A = 4'd1;
    localparam logic [3:0] OP_LOAD_B = 4'd2;
    localparam logic [3:0] OP_ADD    = 4'd3;
    localparam logic [3:0] OP_SUB    = 4'd4;
    localparam logic [3:0] OP_MUL    = 4'd5;
    localparam logic [3:0] OP_DOT    = 4'd6;
    localparam logic [3:0] OP_BUF1   = 4'd7;
    localparam logic [3:0] OP_BUF2   = 4'd8;
    localparam logic [3:0] OP_STORE  = 4'd9;
    localparam logic [3:0] OP_STOP   = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IADDR_W-1:0]     pc_q, pc_d;
    logic [15:0]            ir_q, ir_d;
    logic [LANES*32-1:0]    reg_a_q, reg_a_d;
    logic [LANES*32-1:0]    reg_b_q, reg_b_d;
    logic [LANES*32-1:0]    res_q, res_d;
    logic                   err_q, err_d;
    logic [31:0]            dot_sum;
    logic [3:0]             ir_op;
    logic [3:0]             fetched_op;
    logic                   pc_last;
    logic                   start_ok;

    assign ir_op      = ir_q[15:12];
    assign fetched_op = imem_rdata[15:12];
    assign pc_last    = (pc_q == {IADDR_W{1'b1}});
    assign start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);

    assign imem_addr  = pc_q;
    assign dmem_addr  = ir_q[DADDR_W-1:0];
    assign dmem_wdata = res_q;
    assign pe_a       = reg_a_q;
    assign pe_b       = reg_b_q;
    assign err        = err_q;

    // Instruction address bits above the data address width carry no meaning.
    generate
        if (DADDR_W < 12) begin : g_ir_hi
            logic unused_ir_hi;
            assign unused_ir_hi = ^ir_q[11:DADDR_W];
        end
    endgenerate

    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_sum = dot_sum + pe_out[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = imem_rdata;
                if (fetched_op == OP_STOP) begin
                    state_d = S_DONE;
                end else if (fetched_op > OP_STOP) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (ir_op)
                    OP_ADD, OP_SUB, OP_MUL: res_d = pe_out;
                    OP_DOT: begin
                        res_d       = '0;
                        res_d[31:0] = dot_sum;
                    end
                    OP_BUF1: reg_a_d = res_q;
                    OP_BUF2: reg_b_d = res_q;
                    default: ;
                endcase
                if (ir_op == OP_LOAD_A || ir_op == OP_LOAD_B) begin
                    state_d = S_MEM;
                end else if (pc_last) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (ir_op == OP_LOAD_A) begin
                    reg_a_d = dmem_rdata;
                end else begin
                    reg_b_d = dmem_rdata;
                end
                // Running off the end of program memory is an error, never a wrap.
                if (pc_last) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        dmem_we   = 1'b0;
        pe_opcode = OP_NOP;
        case (state_q)
            S_FETCH, S_DECODE, S_MEM: busy = 1'b1;
            S_EXEC: begin
                busy    = 1'b1;
                dmem_we = (ir_op == OP_STORE);
                if (ir_op inside {OP_ADD, OP_SUB, OP_MUL, OP_DOT}) begin
                    pe_opcode = ir_op;
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef PE_SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            cyc_q <= '0;
        end else if (busy && cyc_q != 32'hFFFF_FFFF) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cycle_count = cyc_q;
`else
    // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: directed and random programs checked cycle-by-cycle against an instruction-level model.
// Define PE_SEQ_CYCLE_CNT_EN for both files to also check cycle_count.
module tb_pe_sequencer;
    logic         clk = 1'b0;
    logic         rst, start;
    logic         busy, done, err, dmem_we;
    logic [7:0]   imem_addr, dmem_addr;
    logic [15:0]  imem_rdata;
    logic [127:0] dmem_rdata, dmem_wdata, pe_a, pe_b, pe_out;
    logic [3:0]   pe_opcode;
`ifdef PE_SEQ_CYCLE_CNT_EN
    logic [31:0]  cycle_count;
`endif

    always #5 clk = ~clk;

    pe_sequencer #(.LANES(4), .IADDR_W(8), .DADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .err(err),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .pe_opcode(pe_opcode), .pe_a(pe_a), .pe_b(pe_b), .pe_out(pe_out)
`ifdef PE_SEQ_CYCLE_CNT_EN
        , .cycle_count(cycle_count)
`endif
    );

    // Environment: synchronous memories and a combinational PE lane array.
    logic [15:0]  imem     [256];
    logic [127:0] mem      [256];
    logic [127:0] init_mem [256];
    logic [127:0] mdl_dmem [256];
    logic         copy_req;

    always @(posedge clk) begin
        imem_rdata <= imem[imem_addr];
        dmem_rdata <= mem[dmem_addr];
        if (copy_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else if (dmem_we) begin
            mem[dmem_addr] <= dmem_wdata;
        end
    end

    function automatic logic [31:0] pe_lane(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd3:       return a + b;
            4'd4:       return a - b;
            4'd5, 4'd6: return a * b;
            default:    return 32'd0;
        endcase
    endfunction

    always_comb begin
        pe_out = '0;
        for (int i = 0; i < 4; i++) pe_out[32*i +: 32] = pe_lane(pe_opcode, pe_a[32*i +: 32], pe_b[32*i +: 32]);
    end

    // Instruction-level model: expected per-cycle outputs while busy.
    typedef struct packed {
        logic         we;
        logic [3:0]   opc;
        logic [7:0]   ia;
        logic [7:0]   da;
        logic [127:0] wd;
    } exp_t;

    exp_t        exp_q[$];
    bit          exp_err;
    int          exp_cycles;
    logic [31:0] m_a[4], m_b[4], m_res[4];
    int          nvec = 0;
    int          nmis = 0;

    function automatic logic [15:0] ins(input int op, input int addr);
        return {op[3:0], 4'd0, addr[7:0]};
    endfunction

    function automatic logic [127:0] pack4(input logic [31:0] l[4]);
        return {l[3], l[2], l[1], l[0]};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic clear_model_regs();
        for (int i = 0; i < 4; i++) begin
            m_a[i] = '0; m_b[i] = '0; m_res[i] = '0;
        end
    endtask

    task automatic build_model();
        int          pc;
        bit          fin;
        logic [3:0]  op;
        logic [7:0]  ad;
        logic [31:0] s;
        logic [127:0] w;
        exp_t        e;
        exp_q.delete();
        exp_err = 1'b0;
        pc = 0;
        fin = 1'b0;
        while (!fin) begin
            op = imem[pc][15:12];
            ad = imem[pc][7:0];
            e.we = 1'b0; e.opc = 4'd0; e.ia = 8'(pc); e.da = 8'd0; e.wd = '0;
            exp_q.push_back(e);
            exp_q.push_back(e);
            if (op == 4'd10) begin
                fin = 1'b1;
            end else if (op > 4'd10) begin
                fin = 1'b1;
                exp_err = 1'b1;
            end else begin
                if (op >= 4'd3 && op <= 4'd6) e.opc = op;
                if (op == 4'd9) begin
                    e.we = 1'b1; e.da = ad; e.wd = pack4(m_res);
                end
                exp_q.push_back(e);
                e.opc = 4'd0; e.we = 1'b0; e.da = 8'd0; e.wd = '0;
                w = mdl_dmem[ad];
                case (op)
                    4'd1: begin exp_q.push_back(e); for (int i = 0; i < 4; i++) m_a[i] = w[32*i +: 32]; end
                    4'd2: begin exp_q.push_back(e); for (int i = 0; i < 4; i++) m_b[i] = w[32*i +: 32]; end
                    4'd3: for (int i = 0; i < 4; i++) m_res[i] = m_a[i] + m_b[i];
                    4'd4: for (int i = 0; i < 4; i++) m_res[i] = m_a[i] - m_b[i];
                    4'd5: for (int i = 0; i < 4; i++) m_res[i] = m_a[i] * m_b[i];
                    4'd6: begin
                        s = '0;
                        for (int i = 0; i < 4; i++) s = s + m_a[i] * m_b[i];
                        m_res[0] = s; m_res[1] = '0; m_res[2] = '0; m_res[3] = '0;
                    end
                    4'd7: for (int i = 0; i < 4; i++) m_a[i] = m_res[i];
                    4'd8: for (int i = 0; i < 4; i++) m_b[i] = m_res[i];
                    4'd9: mdl_dmem[ad] = pack4(m_res);
                    default: ;
                endcase
                if (pc == 255) begin
                    fin = 1'b1;
                    exp_err = 1'b1;
                end else begin
                    pc++;
                end
            end
        end
        exp_cycles = exp_q.size();
    endtask

    task automatic cmp_cycle();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 128'(busy), 128'(1));
            chk("done_in_run", 128'(done), 128'(0));
            chk("err_in_run", 128'(err), 128'(0));
            chk("imem_addr", 128'(imem_addr), 128'(e.ia));
            chk("pe_opcode", 128'(pe_opcode), 128'(e.opc));
            chk("dmem_we", 128'(dmem_we), 128'(e.we));
            if (e.we) begin
                chk("dmem_addr", 128'(dmem_addr), 128'(e.da));
                chk("dmem_wdata", dmem_wdata, e.wd);
            end
        end else begin
            chk("done", 128'(done), 128'(1));
            chk("busy_in_done", 128'(busy), 128'(0));
            chk("err", 128'(err), 128'(exp_err));
            chk("we_in_done", 128'(dmem_we), 128'(0));
            chk("opc_in_done", 128'(pe_opcode), 128'(0));
`ifdef PE_SEQ_CYCLE_CNT_EN
            chk("cycle_count", 128'(cycle_count), 128'(exp_cycles));
`endif
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) mdl_dmem[i] = init_mem[i];
        copy_req = 1'b1;
        @(posedge clk);
        #1 copy_req = 1'b0;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 256; i++) init_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic fill_stop();
        for (int i = 0; i < 256; i++) imem[i] = ins(10, 0);
    endtask

    task automatic prog_p1();
        fill_stop();
        imem[0] = ins(1, 0); imem[1] = ins(2, 1); imem[2] = ins(3, 0);
        imem[3] = ins(9, 2); imem[4] = ins(10, 0);
    endtask

    // Runs the built trace; abort_at>0 pulses rst after that many busy cycles.
    task automatic run_prog(input string nm, input bit glitch, input int abort_at);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cmp_cycle();
            n++;
            if (abort_at > 0 && n == abort_at) break;
            #2 start = glitch && ($urandom_range(0, 5) == 0);
        end
        start = 1'b0;
        if (abort_at > 0 && n == abort_at) begin
            #2 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            exp_q.delete();
            clear_model_regs();
            @(negedge clk);
            chk("abort_busy", 128'(busy), 128'(0));
            chk("abort_done", 128'(done), 128'(0));
            chk("abort_we", 128'(dmem_we), 128'(0));
            chk("abort_pc", 128'(imem_addr), 128'(0));
            $display("run %s: reset after %0d busy cycles", nm, n);
            return;
        end
        repeat (2) begin
            @(negedge clk);
            cmp_cycle();
        end
        for (int i = 0; i < 16; i++) chk("dmem_scoreboard", mem[i], mdl_dmem[i]);
        $display("run %s: %0d busy cycles, err=%0d", nm, n, exp_err);
    endtask

    initial begin
        logic [127:0] lit;
        int len;
        rst = 1'b1; start = 1'b0; copy_req = 1'b0;
        fill_stop();
        rand_mem();
        clear_model_regs();
        load_mem();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_we", 128'(dmem_we), 128'(0));
        chk("rst_opc", 128'(pe_opcode), 128'(0));
        chk("rst_imem_addr", 128'(imem_addr), 128'(0));

        // LOAD_A, LOAD_B, ADD, STORE, STOP
        rand_mem();
        init_mem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        init_mem[1] = {32'd40, 32'd30, 32'd20, 32'd10};
        load_mem();
        prog_p1();
        build_model();
        lit = {32'd44, 32'd33, 32'd22, 32'd11};
        chk("p1_model_cycles", 128'(exp_cycles), 128'(16));
        chk("p1_model_mem2", mdl_dmem[2], lit);
        chk("p1_model_store_slot", 128'(exp_q[13].we), 128'(1));
        run_prog("add_store", 1'b0, 0);
        chk("p1_mem2", mem[2], lit);

        // DOT of {1,2,3,4} and {5,6,7,8}
        rand_mem();
        init_mem[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        init_mem[7] = {32'd8, 32'd7, 32'd6, 32'd5};
        load_mem();
        fill_stop();
        imem[0] = ins(1, 0); imem[1] = ins(2, 7); imem[2] = ins(6, 0); imem[3] = ins(9, 3);
        build_model();
        lit = {96'd0, 32'd70};
        chk("dot_model_mem3", mdl_dmem[3], lit);
        run_prog("dot", 1'b0, 0);
        chk("dot_mem3", mem[3], lit);

        // SUB wraps below zero, MUL keeps low 32 bits
        rand_mem();
        init_mem[8]  = '0;
        init_mem[9]  = {4{32'd1}};
        init_mem[10] = {4{32'h0001_0000}};
        load_mem();
        fill_stop();
        imem[0] = ins(1, 8);  imem[1] = ins(2, 9);  imem[2] = ins(4, 0); imem[3] = ins(9, 5);
        imem[4] = ins(1, 10); imem[5] = ins(2, 10); imem[6] = ins(5, 0); imem[7] = ins(9, 6);
        build_model();
        run_prog("sub_mul", 1'b0, 0);
        lit = {4{32'hFFFF_FFFF}};
        chk("sub_mem5", mem[5], lit);
        lit = '0;
        chk("mul_mem6", mem[6], lit);

        // ADD, BUFFER_RES_1, ADD, STORE with a=b=1
        rand_mem();
        init_mem[9] = {4{32'd1}};
        load_mem();
        fill_stop();
        imem[0] = ins(1, 9); imem[1] = ins(2, 9); imem[2] = ins(3, 0);
        imem[3] = ins(7, 0); imem[4] = ins(3, 0); imem[5] = ins(9, 4);
        build_model();
        run_prog("buffer", 1'b1, 0);
        lit = {4{32'd3}};
        chk("buf_mem4", mem[4], lit);

        // Illegal opcode at pc=0
        fill_stop();
        imem[0] = 16'hF000;
        build_model();
        chk("illegal_model_cycles", 128'(exp_cycles), 128'(2));
        run_prog("illegal", 1'b0, 0);
        chk("illegal_err", 128'(err), 128'(1));

        // Reset during LOAD_A MEM cycle, then during STORE EXEC
        rand_mem();
        load_mem();
        prog_p1();
        build_model();
        run_prog("abort_load", 1'b0, 4);
        prog_p1();
        build_model();
        run_prog("abort_store", 1'b0, 14);

        // Random programs with start pulses while busy
        for (int r = 0; r < 10; r++) begin
            rand_mem();
            load_mem();
            fill_stop();
            len = $urandom_range(1, 30);
            for (int k = 0; k < len; k++) imem[k] = ins($urandom_range(0, 9), $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) imem[len] = ins($urandom_range(11, 15), 0);
            build_model();
            run_prog("random", 1'b1, 0);
        end

        // No STOP anywhere: runs off the end of program memory
        rand_mem();
        load_mem();
        for (int k = 0; k < 256; k++) imem[k] = ins($urandom_range(0, 9), $urandom_range(0, 15));
        build_model();
        chk("overflow_model_err", 128'(exp_err), 128'(1));
        run_prog("pc_overflow", 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
